// File: rtl/lorenz_pkg.sv
// Shared types and constants for the Lorenz integrator datapath.
// State variables are signed 7.20 fixed point; a sample is the packed triple {x, y, z}.
package lorenz_pkg;

  localparam int N    = 27;
  localparam int FRAC = 20;

  typedef logic signed [N-1:0] state_t;

  typedef struct packed {
    state_t x;
    state_t y;
    state_t z;
  } sample_t;

  // Pack the three state variables with x in the MSBs, bit-exact.
  function automatic sample_t pack_sample(input state_t sx, input state_t sy, input state_t sz);
    sample_t s;
    s.x = sx;
    s.y = sy;
    s.z = sz;
    return s;
  endfunction

endpackage

// File: rtl/lorenz_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with a registered head word.
// fill is an explicit counter so full (fill == 2**AW) needs no extra pointer bit.
module lorenz_sync_fifo #(
  parameter int W  = 81,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   fill_o
);

  localparam int          DEPTH    = 2 ** AW;
  localparam logic [AW:0] FULL_LVL = (AW + 1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   fill_q, fill_d;
  logic [AW:0]   remain_s;
  logic [W-1:0]  head_q, head_d;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign full_o  = (fill_q == FULL_LVL);
  assign empty_o = (fill_q == {(AW + 1){1'b0}});
  assign fill_o  = fill_q;
  assign rdata_o = head_q;

  // Next-state for pointers, level and the registered head word.
  always_comb begin
    pop_ok_s  = pop_i && !empty_o;
    push_ok_s = push_i && (!full_o || pop_ok_s);
    wr_d      = push_ok_s ? (wr_q + AW'(1)) : wr_q;
    rd_d      = pop_ok_s ? (rd_q + AW'(1)) : rd_q;
    remain_s  = fill_q - {{AW{1'b0}}, pop_ok_s};
    fill_d    = remain_s + {{AW{1'b0}}, push_ok_s};
    // The head after this edge is either nothing, the word being written
    // (no older entry survives), or the oldest surviving stored entry.
    if (fill_d == {(AW + 1){1'b0}}) begin
      head_d = {W{1'b0}};
    end else if (remain_s == {(AW + 1){1'b0}}) begin
      head_d = wdata_i;
    end else begin
      head_d = mem_q[rd_d];
    end
  end

  // Storage array; contents need no reset since fill gates visibility.
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_q[wr_q] <= wdata_i;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q   <= {AW{1'b0}};
      rd_q   <= {AW{1'b0}};
      fill_q <= {(AW + 1){1'b0}};
      head_q <= {W{1'b0}};
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      fill_q <= fill_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/lorenz_sample_fifo.sv
// Decimates the free-running Lorenz state vector and buffers the samples
// in a FWFT FIFO on a valid/ready stream, with sticky overflow accounting.
module lorenz_sample_fifo
  import lorenz_pkg::*;
#(
  parameter int DECIM_W = 16,
  parameter int AW      = 4,
  parameter int DROP_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 run,
  input  logic [DECIM_W-1:0]   decim,
  input  logic [N-1:0]         x,
  input  logic [N-1:0]         y,
  input  logic [N-1:0]         z,
  input  logic                 clr_ovf,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3*N-1:0]       out_data,
  output logic [AW:0]          fill,
  output logic                 overflow,
  output logic [DROP_W-1:0]    drop_cnt
);

  localparam logic [DROP_W-1:0] DROP_MAX = {DROP_W{1'b1}};

  logic [DECIM_W-1:0] cnt_q, cnt_d;
  logic               strobe_s;
  logic               pop_s;
  logic               push_s;
  logic               drop_s;
  logic               full_s;
  logic               empty_s;
  logic               overflow_q, overflow_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  sample_t            sample_s;

  assign sample_s  = pack_sample(state_t'(x), state_t'(y), state_t'(z));
  assign out_valid = !empty_s;
  assign overflow  = overflow_q;
  assign drop_cnt  = drop_cnt_q;

  // Decimation counter; >= lets a lowered ratio take effect on the next edge.
  always_comb begin
    strobe_s = 1'b0;
    cnt_d    = cnt_q;
    if (!run) begin
      cnt_d = {DECIM_W{1'b0}};
    end else if (cnt_q >= decim) begin
      strobe_s = 1'b1;
      cnt_d    = {DECIM_W{1'b0}};
    end else begin
      cnt_d = cnt_q + DECIM_W'(1);
    end
  end

  // Push/pop/drop decisions; a full FIFO still accepts when it pops this cycle.
  always_comb begin
    pop_s  = out_ready && !empty_s;
    drop_s = strobe_s && full_s && !pop_s;
    push_s = strobe_s && !drop_s;
  end

  // Sticky overflow and saturating drop count; a drop beats a clear.
  always_comb begin
    overflow_d = overflow_q;
    drop_cnt_d = drop_cnt_q;
    if (drop_s) begin
      overflow_d = 1'b1;
      if (clr_ovf) begin
        drop_cnt_d = DROP_W'(1);
      end else if (drop_cnt_q == DROP_MAX) begin
        drop_cnt_d = drop_cnt_q;
      end else begin
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
      end
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
      drop_cnt_d = {DROP_W{1'b0}};
    end else begin
      overflow_d = overflow_q;
      drop_cnt_d = drop_cnt_q;
    end
  end

  // Parent-side state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q      <= {DECIM_W{1'b0}};
      overflow_q <= 1'b0;
      drop_cnt_q <= {DROP_W{1'b0}};
    end else begin
      cnt_q      <= cnt_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  lorenz_sync_fifo #(
    .W  ($bits(sample_t)),
    .AW (AW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .wdata_i (sample_s),
    .rdata_o (out_data),
    .full_o  (full_s),
    .empty_o (empty_s),
    .fill_o  (fill)
  );

endmodule

// File: tb/tb_lorenz_sample_fifo.sv
// Bench for lorenz_sample_fifo: a reference model fed by the stimulus pushes
// expected samples into a queue, a negedge monitor pops and compares them,
// and directed checks confirm hand-computed values for each scenario.
module tb_lorenz_sample_fifo;

  logic        clk;
  logic        reset;
  logic        run;
  logic [15:0] decim;
  logic [26:0] x, y, z;
  logic        clr_ovf;
  logic        out_valid;
  logic        out_ready;
  logic [80:0] out_data;
  logic [4:0]  fill;
  logic        overflow;
  logic [15:0] drop_cnt;

  int          total;
  int          bad;
  logic [80:0] sb[$];
  logic [26:0] inc;

  logic [15:0] m_cnt;
  int          m_fill;
  logic        m_ovf;
  logic [15:0] m_drop;
  bit          m_pop, m_strobe, m_push;

  lorenz_sample_fifo dut (
    .clk       (clk),
    .reset     (reset),
    .run       (run),
    .decim     (decim),
    .x         (x),
    .y         (y),
    .z         (z),
    .clr_ovf   (clr_ovf),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .fill      (fill),
    .overflow  (overflow),
    .drop_cnt  (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [80:0] act, input logic [80:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic setx(input logic [26:0] v);
    x = v;
    y = v + 27'h1;
    z = v + 27'h2;
  endtask

  // One clock: return 1 time unit after the edge, then advance the ramp.
  task automatic cyc();
    @(posedge clk);
    #1;
    setx(x + inc);
  endtask

  // Reference model evaluated on each active edge with the inputs in force.
  initial begin
    m_cnt = 16'h0; m_fill = 0; m_ovf = 1'b0; m_drop = 16'h0;
    forever begin
      @(posedge clk);
      if (reset !== 1'b1) begin
        m_cnt = 16'h0; m_fill = 0; m_ovf = 1'b0; m_drop = 16'h0;
        sb.delete();
      end else begin
        m_pop    = (m_fill != 0) && out_ready;
        m_strobe = run && (m_cnt >= decim);
        m_cnt    = !run ? 16'h0 : (m_strobe ? 16'h0 : m_cnt + 16'h1);
        m_push   = 1'b0;
        if (m_strobe) begin
          if (m_fill < 16 || m_pop) begin
            m_push = 1'b1;
            sb.push_back({x, y, z});
          end else begin
            m_ovf  = 1'b1;
            m_drop = clr_ovf ? 16'h1 : ((m_drop == 16'hFFFF) ? m_drop : m_drop + 16'h1);
          end
        end else if (clr_ovf) begin
          m_ovf  = 1'b0;
          m_drop = 16'h0;
        end
        if (m_strobe && !m_push) begin
          // drop already accounted above
        end else if (clr_ovf && m_strobe) begin
          m_ovf  = 1'b0;
          m_drop = 16'h0;
        end
        m_fill = m_fill + (m_push ? 1 : 0) - (m_pop ? 1 : 0);
      end
    end
  end

  // Monitor: compare the presented head against the scoreboard front.
  initial begin
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        chk("mon_fill", 81'(fill), 81'(m_fill));
        chk("mon_valid", 81'(out_valid), 81'(m_fill != 0));
        chk("mon_ovf", 81'(overflow), 81'(m_ovf));
        chk("mon_drop", 81'(drop_cnt), 81'(m_drop));
        if (out_valid) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL mon_data: got %h expected no sample", out_data);
          end else begin
            chk("mon_data", out_data, sb[0]);
            if (out_ready) begin
              void'(sb.pop_front());
            end
          end
        end else begin
          chk("mon_idle_data", out_data, 81'h0);
        end
      end
    end
  end

  logic [26:0] got [4];
  logic [26:0] exp2 [4];
  logic [26:0] hx;
  int nv, maxfill, errs;

  initial begin
    total = 0; bad = 0;
    reset = 1'b0; run = 1'b0; decim = 16'h0; clr_ovf = 1'b0; out_ready = 1'b0;
    inc = 27'h0; setx(27'h0);
    exp2[0] = 27'h0300000; exp2[1] = 27'h0700000;
    exp2[2] = 27'h0B00000; exp2[3] = 27'h0F00000;

    // Reset state
    cyc(); cyc();
    chk("rst_valid", 81'(out_valid), 81'h0);
    chk("rst_fill", 81'(fill), 81'h0);
    chk("rst_ovf", 81'(overflow), 81'h0);
    chk("rst_drop", 81'(drop_cnt), 81'h0);
    chk("rst_data", out_data, 81'h0);

    // Reset mid-stream with a half-full FIFO
    reset = 1'b1; run = 1'b1; decim = 16'd0; inc = 27'h1; setx(27'h10);
    repeat (8) cyc();
    chk("t1_half", 81'(fill), 81'd8);
    reset = 1'b0;
    cyc();
    chk("t1_valid", 81'(out_valid), 81'h0);
    chk("t1_fill", 81'(fill), 81'h0);
    chk("t1_ovf", 81'(overflow), 81'h0);
    chk("t1_drop", 81'(drop_cnt), 81'h0);
    chk("t1_data", out_data, 81'h0);
    reset = 1'b1; run = 1'b0;
    cyc();

    // decim=3 streaming at 1.0 per clock
    setx(27'h0); inc = 27'h0100000; decim = 16'd3; out_ready = 1'b1; run = 1'b1;
    nv = 0; maxfill = 0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      if (int'(fill) > maxfill) maxfill = int'(fill);
      if (out_valid) begin
        if (nv < 4) got[nv] = out_data[80:54];
        nv++;
      end
    end
    chk("t2_count", 81'(nv), 81'd4);
    chk("t2_maxfill", 81'(maxfill), 81'd1);
    for (int i = 0; i < 4; i++) begin
      chk("t2_sample", 81'(got[i]), 81'(exp2[i]));
    end
    run = 1'b0;
    cyc(); cyc();
    chk("t2_drained", 81'(fill), 81'h0);

    // Stall: fill to 16, then four drops
    setx(27'h1000); inc = 27'h1; decim = 16'd0; out_ready = 1'b0; run = 1'b1;
    repeat (16) cyc();
    chk("t3_full", 81'(fill), 81'd16);
    chk("t3_noovf", 81'(overflow), 81'h0);
    repeat (4) cyc();
    chk("t3_fill", 81'(fill), 81'd16);
    chk("t3_ovf", 81'(overflow), 81'h1);
    chk("t3_drop", 81'(drop_cnt), 81'd4);
    chk("t3_head", out_data, {27'h1000, 27'h1001, 27'h1002});

    // Full FIFO with push and pop every cycle
    out_ready = 1'b1;
    errs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      if (fill !== 5'd16) errs++;
    end
    chk("t4_fill_steady", 81'(errs), 81'h0);
    chk("t4_nodrop", 81'(drop_cnt), 81'd4);
    run = 1'b0;
    repeat (16) cyc();
    chk("t4_drained", 81'(fill), 81'h0);

    // decim lowered from 100 to 10 mid-run at cnt=50
    decim = 16'd100; run = 1'b1; errs = 0;
    for (int i = 0; i < 50; i++) begin
      cyc();
      if (out_valid) errs++;
    end
    chk("t5_quiet", 81'(errs), 81'h0);
    decim = 16'd10;
    cyc();
    chk("t5_first", 81'(out_valid), 81'h1);
    for (int k = 0; k < 2; k++) begin
      errs = 0;
      for (int i = 0; i < 10; i++) begin
        cyc();
        if (out_valid) errs++;
      end
      chk("t5_gap", 81'(errs), 81'h0);
      cyc();
      chk("t5_next", 81'(out_valid), 81'h1);
    end
    run = 1'b0;
    cyc(); cyc();

    // clr_ovf without and with a simultaneous drop
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0;
    chk("t6_clr_ovf", 81'(overflow), 81'h0);
    chk("t6_clr_drop", 81'(drop_cnt), 81'h0);
    decim = 16'd0; out_ready = 1'b0; run = 1'b1;
    repeat (16) cyc();
    chk("t6_full", 81'(fill), 81'd16);
    clr_ovf = 1'b1;
    cyc();
    clr_ovf = 1'b0; run = 1'b0;
    chk("t6_race_ovf", 81'(overflow), 81'h1);
    chk("t6_race_drop", 81'(drop_cnt), 81'd1);
    out_ready = 1'b1;
    repeat (16) cyc();
    chk("t6_drained", 81'(fill), 81'h0);

    // Negative value bit-exact
    inc = 27'h0; setx(27'h7E80000); out_ready = 1'b0; run = 1'b1;
    cyc();
    run = 1'b0;
    hx = out_data[80:54];
    chk("t6_neg_valid", 81'(out_valid), 81'h1);
    chk("t6_neg_x", 81'(hx), 81'h7E80000);
    chk("t6_neg_all", out_data, {27'h7E80000, 27'h7E80001, 27'h7E80002});
    out_ready = 1'b1;
    cyc(); cyc();
    chk("end_fill", 81'(fill), 81'h0);
    chk("end_sb", 81'(sb.size()), 81'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
